axil_reg_slave: RTL and testbench
=================================

Name: axil_reg_slave

Overview:
AXI4-Lite responder that exposes a bank of 32-bit registers to a bus initiator, the bus-facing counterpart of the core's register storage.
- Accepts single-beat writes (with byte strobes) and reads over the five AXI4-Lite channels.
- Provides one combinational core-side read port, so logic inside the core can observe register contents directly.
- Sits between the AXI4-Lite interconnect and peripheral/control logic of the RISC-V system.

Parameters:
ADDR_W, 7, AXI address width in bits; word index = addr[ADDR_W-1:2].
DATA_W, 32, data width; fixed at 32, and any other value is unsupported.
NUM_REGS, 32, number of implemented registers; must satisfy NUM_REGS <= 2^(ADDR_W-2).

Ports:
clk  input  1  system clock, rising edge
reset_n  input  1  asynchronous active-low reset
s_awaddr  input  ADDR_W  write address
s_awvalid  input  1  write address valid
s_awready  output  1  write address ready
s_wdata  input  32  write data
s_wstrb  input  4  byte enables, bit i covers bits 8i+7:8i
s_wvalid  input  1  write data valid
s_wready  output  1  write data ready
s_bresp  output  2  write response
s_bvalid  output  1  write response valid
s_bready  input  1  write response ready
s_araddr  input  ADDR_W  read address
s_arvalid  input  1  read address valid
s_arready  output  1  read address ready
s_rdata  output  32  read data
s_rresp  output  2  read response
s_rvalid  output  1  read data valid
s_rready  input  1  read data ready
core_rd_addr  input  5  core-side register index
core_rd_data  output  32  combinational read of reg[core_rd_addr]; 0 if index >= NUM_REGS

Behaviour:
- Reset (reset_n=0, asynchronous), all take effect immediately:
  - every register = 0
  - bvalid = 0, rvalid = 0, bresp = 00, rresp = 00, rdata = 0
  - AW/W hold flags cleared, both FSMs in IDLE
- Ready outputs (combinational from state):
  - awready = (wstate==W_IDLE) & !aw_held
  - wready = (wstate==W_IDLE) & !w_held
  - arready = (rstate==R_IDLE)
- Write FSM, states W_IDLE and W_RESP:
  - In W_IDLE, AW and W are accepted independently, in either order or in the same cycle. Each accepted beat is latched and sets its held flag.
  - At the edge where both AW and W are available (held, or handshaking that cycle), the write commits:
    - each byte with wstrb=1 is updated; bytes with wstrb=0 are unchanged
    - bresp = 00 (OKAY) if index < NUM_REGS; otherwise 10 (SLVERR) and no register changes
    - bvalid <= 1, held flags cleared, state -> W_RESP
  - In W_RESP, bvalid and bresp are held stable until bready=1. Then bvalid <= 0 and state -> W_IDLE.
  - wstrb = 0 gives OKAY with no change.
  - Latency: AW+W in the same cycle gives bvalid on the next cycle. Maximum throughput is one write per 2 cycles when bready is tied high.
- Read FSM, states R_IDLE and R_VALID:
  - On AR handshake: rdata <= reg[index] (or 0 with rresp=10 if index >= NUM_REGS), rresp <= 00 otherwise, rvalid <= 1, state -> R_VALID.
  - In R_VALID, rdata and rresp are held stable until rready=1. Then rvalid <= 0 and state -> R_IDLE.
  - Latency: 1 cycle from AR handshake to rvalid.
- Address handling: addr[1:0] is ignored, with no alignment error.
- Read and write channels are fully independent; both may complete in the same cycle.
- Same-edge write commit and AR handshake to the same index: the read returns the pre-write value.
- core_rd_data reflects a committed write from the cycle after the commit edge. There is no bypass.
- Reset asserted mid-transaction: outstanding responses are dropped and held beats are discarded. The initiator must also be reset.

Decomposition:
- Package axil_pkg holds:
  - RESP_OKAY = 2'b00, RESP_SLVERR = 2'b10
  - write state enum {W_IDLE, W_RESP} and read state enum {R_IDLE, R_VALID}
  - helper function for the word index
- Sub-module axil_reg_array holds the storage: NUM_REGS x 32, async-reset to 0, one byte-strobed write port, two combinational read ports (AXI read path and core_rd port).
- axil_reg_slave holds both FSMs and the hold registers.

Test Plan:
- AW+W same cycle, addr 0x08, data 0xDEADBEEF, strb 1111, bready=1 -> bvalid on next cycle, bresp=00; AR 0x08 -> rvalid 1 cycle later, rdata=0xDEADBEEF, rresp=00.
- W sent 3 cycles before AW (addr 0x0C, data 0x11223344) -> wready low while W is held; commit after AW; bvalid the cycle after the AW handshake; core_rd_addr=3 shows 0x11223344.
- reg[2]=0xFFFFFFFF, then write 0x00000000 with strb 0101 -> reg[2]=0xFF00FF00; with wstrb=0000 -> unchanged, bresp=00.
- bready and rready held low for 5 cycles -> bvalid/rvalid, bresp/rresp and rdata remain stable; awready, wready and arready stay low; new AR/AW are not accepted until release.
- Same-edge write to index 4 (old 0x5, new 0x9) and AR to index 4 -> rdata=0x5; a subsequent read returns 0x9.
- Build with NUM_REGS=16: write to addr 0x40 -> bresp=10 and no register changed; read addr 0x40 -> rresp=10, rdata=0. Assert reset_n low while bvalid=1 -> bvalid=0 immediately and all registers read 0.

Source files
------------

// File: rtl/axil_pkg.sv
// Shared constants and helpers for the AXI4-Lite register responder.
package axil_pkg;

    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_SLVERR = 2'b10;

    localparam logic W_IDLE  = 1'b0;
    localparam logic W_RESP  = 1'b1;

    localparam logic R_IDLE  = 1'b0;
    localparam logic R_VALID = 1'b1;

    // Byte address to 32-bit word index; the two low bits are dropped.
    function automatic int unsigned word_index(input logic [31:0] addr);
        return addr >> 2;
    endfunction

endpackage

// File: rtl/axil_reg_array.sv
// Register storage: NUM_REGS x 32 bits, one byte-strobed write port and two
// combinational read ports (bus read path and core-side observation port).
module axil_reg_array #(
    parameter int unsigned NUM_REGS = 32,
    parameter int unsigned IDX_W    = 5
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             we,
    input  logic [IDX_W-1:0] wr_idx,
    input  logic [31:0]      wr_data,
    input  logic [3:0]       wr_strb,
    input  logic [IDX_W-1:0] rd_idx,
    output logic [31:0]      rd_data,
    input  logic [4:0]       core_idx,
    output logic [31:0]      core_data
);

    logic [31:0] mem [NUM_REGS];

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            for (int unsigned i = 0; i < NUM_REGS; i++) begin
                mem[i] <= '0;
            end
        end else if (we) begin
            for (int unsigned i = 0; i < NUM_REGS; i++) begin
                if (32'(wr_idx) == i) begin
                    for (int unsigned b = 0; b < 4; b++) begin
                        if (wr_strb[b]) begin
                            mem[i][8*b +: 8] <= wr_data[8*b +: 8];
                        end
                    end
                end
            end
        end
    end

    // Indices outside the implemented range fall through to zero.
    always_comb begin
        rd_data   = '0;
        core_data = '0;
        for (int unsigned i = 0; i < NUM_REGS; i++) begin
            if (32'(rd_idx) == i) begin
                rd_data = mem[i];
            end
            if (32'(core_idx) == i) begin
                core_data = mem[i];
            end
        end
    end

endmodule

// File: rtl/axil_reg_slave.sv
// AXI4-Lite responder over a bank of 32-bit registers with a combinational
// core-side read port. Independent write (AW/W/B) and read (AR/R) FSMs.
module axil_reg_slave
    import axil_pkg::*;
#(
    parameter int unsigned ADDR_W   = 7,
    parameter int unsigned DATA_W   = 32,
    parameter int unsigned NUM_REGS = 32
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic [ADDR_W-1:0] s_awaddr,
    input  logic              s_awvalid,
    output logic              s_awready,
    input  logic [DATA_W-1:0] s_wdata,
    input  logic [3:0]        s_wstrb,
    input  logic              s_wvalid,
    output logic              s_wready,
    output logic [1:0]        s_bresp,
    output logic              s_bvalid,
    input  logic              s_bready,
    input  logic [ADDR_W-1:0] s_araddr,
    input  logic              s_arvalid,
    output logic              s_arready,
    output logic [DATA_W-1:0] s_rdata,
    output logic [1:0]        s_rresp,
    output logic              s_rvalid,
    input  logic              s_rready,
    input  logic [4:0]        core_rd_addr,
    output logic [DATA_W-1:0] core_rd_data
);

    localparam int unsigned IDX_W = ADDR_W - 2;

    logic              wstate_q;
    logic              aw_held_q;
    logic              w_held_q;
    logic [ADDR_W-1:0] awaddr_q;
    logic [DATA_W-1:0] wdata_q;
    logic [3:0]        wstrb_q;
    logic              bvalid_q;
    logic [1:0]        bresp_q;

    logic              rstate_q;
    logic              rvalid_q;
    logic [1:0]        rresp_q;
    logic [DATA_W-1:0] rdata_q;

    logic              aw_hs;
    logic              w_hs;
    logic              ar_hs;
    logic              commit;
    logic [ADDR_W-1:0] cur_awaddr;
    logic [DATA_W-1:0] cur_wdata;
    logic [3:0]        cur_wstrb;
    int unsigned       wr_word;
    int unsigned       rd_word;
    logic              wr_in_range;
    logic              rd_in_range;
    logic [DATA_W-1:0] arr_rd_data;

    assign s_awready = (wstate_q == W_IDLE) && !aw_held_q;
    assign s_wready  = (wstate_q == W_IDLE) && !w_held_q;
    assign s_arready = (rstate_q == R_IDLE);

    assign aw_hs = s_awvalid && s_awready;
    assign w_hs  = s_wvalid && s_wready;
    assign ar_hs = s_arvalid && s_arready;

    // A beat is usable either from its hold register or from a live handshake.
    assign cur_awaddr = aw_held_q ? awaddr_q : s_awaddr;
    assign cur_wdata  = w_held_q ? wdata_q : s_wdata;
    assign cur_wstrb  = w_held_q ? wstrb_q : s_wstrb;

    assign commit = (wstate_q == W_IDLE) && (aw_held_q || aw_hs) && (w_held_q || w_hs);

    assign wr_word     = word_index(32'(cur_awaddr));
    assign rd_word     = word_index(32'(s_araddr));
    assign wr_in_range = wr_word < NUM_REGS;
    assign rd_in_range = rd_word < NUM_REGS;

    axil_reg_array #(
        .NUM_REGS (NUM_REGS),
        .IDX_W    (IDX_W)
    ) u_reg_array (
        .clk       (clk),
        .reset_n   (reset_n),
        .we        (commit && wr_in_range),
        .wr_idx    (IDX_W'(wr_word)),
        .wr_data   (cur_wdata),
        .wr_strb   (cur_wstrb),
        .rd_idx    (IDX_W'(rd_word)),
        .rd_data   (arr_rd_data),
        .core_idx  (core_rd_addr),
        .core_data (core_rd_data)
    );

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            wstate_q  <= W_IDLE;
            aw_held_q <= 1'b0;
            w_held_q  <= 1'b0;
            awaddr_q  <= '0;
            wdata_q   <= '0;
            wstrb_q   <= '0;
            bvalid_q  <= 1'b0;
            bresp_q   <= RESP_OKAY;
        end else if (wstate_q == W_IDLE) begin
            if (commit) begin
                bvalid_q  <= 1'b1;
                bresp_q   <= wr_in_range ? RESP_OKAY : RESP_SLVERR;
                aw_held_q <= 1'b0;
                w_held_q  <= 1'b0;
                wstate_q  <= W_RESP;
            end else begin
                if (aw_hs) begin
                    aw_held_q <= 1'b1;
                    awaddr_q  <= s_awaddr;
                end
                if (w_hs) begin
                    w_held_q <= 1'b1;
                    wdata_q  <= s_wdata;
                    wstrb_q  <= s_wstrb;
                end
            end
        end else if (s_bready) begin
            bvalid_q <= 1'b0;
            wstate_q <= W_IDLE;
        end
    end

    // The array is read before the same-edge write lands, so a colliding
    // read returns the pre-write value.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            rstate_q <= R_IDLE;
            rvalid_q <= 1'b0;
            rresp_q  <= RESP_OKAY;
            rdata_q  <= '0;
        end else if (rstate_q == R_IDLE) begin
            if (ar_hs) begin
                rdata_q  <= rd_in_range ? arr_rd_data : '0;
                rresp_q  <= rd_in_range ? RESP_OKAY : RESP_SLVERR;
                rvalid_q <= 1'b1;
                rstate_q <= R_VALID;
            end
        end else if (s_rready) begin
            rvalid_q <= 1'b0;
            rstate_q <= R_IDLE;
        end
    end

    assign s_bvalid = bvalid_q;
    assign s_bresp  = bresp_q;
    assign s_rvalid = rvalid_q;
    assign s_rresp  = rresp_q;
    assign s_rdata  = rdata_q;

endmodule

// File: tb/tb_axil_reg_slave.sv
// Randomized self-checking bench for axil_reg_slave against an array model.
module tb_axil_reg_slave;

    localparam int unsigned NR = 16;

    logic        clk = 1'b0;
    logic        reset_n;
    logic [6:0]  s_awaddr;
    logic        s_awvalid;
    logic        s_awready;
    logic [31:0] s_wdata;
    logic [3:0]  s_wstrb;
    logic        s_wvalid;
    logic        s_wready;
    logic [1:0]  s_bresp;
    logic        s_bvalid;
    logic        s_bready;
    logic [6:0]  s_araddr;
    logic        s_arvalid;
    logic        s_arready;
    logic [31:0] s_rdata;
    logic [1:0]  s_rresp;
    logic        s_rvalid;
    logic        s_rready;
    logic [4:0]  core_rd_addr;
    logic [31:0] core_rd_data;

    int vectors    = 0;
    int miscompares = 0;

    logic [31:0] model [32];

    axil_reg_slave #(
        .ADDR_W   (7),
        .DATA_W   (32),
        .NUM_REGS (NR)
    ) dut (
        .clk          (clk),
        .reset_n      (reset_n),
        .s_awaddr     (s_awaddr),
        .s_awvalid    (s_awvalid),
        .s_awready    (s_awready),
        .s_wdata      (s_wdata),
        .s_wstrb      (s_wstrb),
        .s_wvalid     (s_wvalid),
        .s_wready     (s_wready),
        .s_bresp      (s_bresp),
        .s_bvalid     (s_bvalid),
        .s_bready     (s_bready),
        .s_araddr     (s_araddr),
        .s_arvalid    (s_arvalid),
        .s_arready    (s_arready),
        .s_rdata      (s_rdata),
        .s_rresp      (s_rresp),
        .s_rvalid     (s_rvalid),
        .s_rready     (s_rready),
        .core_rd_addr (core_rd_addr),
        .core_rd_data (core_rd_data)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [31:0] model_read(input logic [6:0] addr);
        int unsigned idx = 32'(addr) / 4;
        return (idx < NR) ? model[idx] : 32'h0;
    endfunction

    function automatic logic [1:0] model_resp(input logic [6:0] addr);
        return ((32'(addr) / 4) < NR) ? 2'b00 : 2'b10;
    endfunction

    task automatic model_write(input logic [6:0] addr, input logic [31:0] data,
                               input logic [3:0] strb);
        int unsigned idx = 32'(addr) / 4;
        if (idx < NR) begin
            for (int b = 0; b < 4; b++) begin
                if (strb[b]) model[idx][8*b +: 8] = data[8*b +: 8];
            end
        end
    endtask

    task automatic model_clear();
        for (int i = 0; i < 32; i++) model[i] = 32'h0;
    endtask

    // Drives one write with independent AW/W start delays; lat counts cycles
    // after the last handshake edge until bvalid is seen.
    task automatic do_write(input logic [6:0] addr, input logic [31:0] data,
                            input logic [3:0] strb, input int aw_dly, input int w_dly,
                            output logic [1:0] resp, output int lat, output bit ok);
        bit aw_done = 0;
        bit w_done  = 0;
        bit a, w;
        int cyc = 0;
        s_awaddr = addr;
        s_wdata  = data;
        s_wstrb  = strb;
        while (!(aw_done && w_done) && cyc < 40) begin
            s_awvalid = !aw_done && (cyc >= aw_dly);
            s_wvalid  = !w_done && (cyc >= w_dly);
            a = s_awvalid && s_awready;
            w = s_wvalid && s_wready;
            tick();
            if (a) aw_done = 1;
            if (w) w_done = 1;
            cyc++;
        end
        s_awvalid = 0;
        s_wvalid  = 0;
        lat = 0;
        while (!s_bvalid && lat < 10) begin
            tick();
            lat++;
        end
        ok   = aw_done && w_done && s_bvalid;
        resp = s_bresp;
        if (s_bready) tick();
    endtask

    task automatic do_read(input logic [6:0] addr, output logic [31:0] data,
                           output logic [1:0] resp, output int lat, output bit ok);
        int cyc = 0;
        s_araddr  = addr;
        s_arvalid = 1;
        while (!s_arready && cyc < 20) begin
            tick();
            cyc++;
        end
        tick();
        s_arvalid = 0;
        lat = 0;
        while (!s_rvalid && lat < 10) begin
            tick();
            lat++;
        end
        ok   = s_rvalid;
        data = s_rdata;
        resp = s_rresp;
        if (s_rready) tick();
    endtask

    task automatic test_reset();
        bit bad = 0;
        vectors++;
        if ({s_bvalid, s_rvalid, s_bresp, s_rresp, s_rdata} !== 38'h0) begin
            miscompares++;
            $display("FAIL reset_outputs: got bv=%0b rv=%0b br=%0b rr=%0b rd=%h want all 0",
                     s_bvalid, s_rvalid, s_bresp, s_rresp, s_rdata);
        end
        vectors++;
        if ({s_awready, s_wready, s_arready} !== 3'b111) begin
            miscompares++;
            $display("FAIL reset_ready: got %b want 111", {s_awready, s_wready, s_arready});
        end
        for (int i = 0; i < 32; i++) begin
            core_rd_addr = 5'(i);
            #1;
            if (core_rd_data !== 32'h0) bad = 1;
        end
        vectors++;
        if (bad) begin
            miscompares++;
            $display("FAIL reset_regs: some register nonzero, want all 0");
        end
    endtask

    task automatic test_basic();
        logic [1:0]  resp;
        logic [31:0] data;
        int lat;
        bit ok;
        do_write(7'h08, 32'hDEADBEEF, 4'hF, 0, 0, resp, lat, ok);
        model_write(7'h08, 32'hDEADBEEF, 4'hF);
        vectors++;
        if (!ok || resp !== 2'b00 || lat !== 0) begin
            miscompares++;
            $display("FAIL basic_write: ok=%0b resp=%b lat=%0d want 1/00/0", ok, resp, lat);
        end
        do_read(7'h08, data, resp, lat, ok);
        vectors++;
        if (!ok || data !== 32'hDEADBEEF || resp !== 2'b00 || lat !== 0) begin
            miscompares++;
            $display("FAIL basic_read: ok=%0b data=%h resp=%b lat=%0d want 1/deadbeef/00/0",
                     ok, data, resp, lat);
        end
    endtask

    task automatic test_w_before_aw();
        s_wdata  = 32'h11223344;
        s_wstrb  = 4'hF;
        s_wvalid = 1;
        tick();
        s_wvalid = 0;
        for (int k = 0; k < 3; k++) begin
            vectors++;
            if (s_wready !== 1'b0 || s_bvalid !== 1'b0 || s_awready !== 1'b1) begin
                miscompares++;
                $display("FAIL w_held_%0d: wready=%b bvalid=%b awready=%b want 0/0/1",
                         k, s_wready, s_bvalid, s_awready);
            end
            tick();
        end
        s_awaddr  = 7'h0C;
        s_awvalid = 1;
        tick();
        s_awvalid = 0;
        model_write(7'h0C, 32'h11223344, 4'hF);
        core_rd_addr = 5'd3;
        #1;
        vectors++;
        if (s_bvalid !== 1'b1 || s_bresp !== 2'b00 || core_rd_data !== 32'h11223344) begin
            miscompares++;
            $display("FAIL w_first_commit: bvalid=%b bresp=%b core=%h want 1/00/11223344",
                     s_bvalid, s_bresp, core_rd_data);
        end
        tick();
    endtask

    task automatic test_strobes();
        logic [1:0] resp;
        int lat;
        bit ok;
        core_rd_addr = 5'd2;
        do_write(7'h08, 32'hFFFFFFFF, 4'hF, 0, 0, resp, lat, ok);
        model_write(7'h08, 32'hFFFFFFFF, 4'hF);
        do_write(7'h08, 32'h00000000, 4'b0101, 1, 0, resp, lat, ok);
        model_write(7'h08, 32'h00000000, 4'b0101);
        vectors++;
        if (core_rd_data !== model[2] || resp !== 2'b00) begin
            miscompares++;
            $display("FAIL strb_0101: got %h resp=%b want %h/00", core_rd_data, resp, model[2]);
        end
        do_write(7'h0A, 32'h12345678, 4'b0000, 0, 2, resp, lat, ok);
        vectors++;
        if (core_rd_data !== 32'hFF00FF00 || resp !== 2'b00 || !ok) begin
            miscompares++;
            $display("FAIL strb_0000: got %h resp=%b ok=%0b want ff00ff00/00/1",
                     core_rd_data, resp, ok);
        end
    endtask

    task automatic test_backpressure();
        logic [31:0] exp_rd;
        logic [31:0] wval = $urandom;
        s_bready = 0;
        s_rready = 0;
        exp_rd = model_read(7'h08);
        s_awaddr = 7'h14; s_wdata = wval; s_wstrb = 4'hF; s_araddr = 7'h08;
        s_awvalid = 1; s_wvalid = 1; s_arvalid = 1;
        tick();
        model_write(7'h14, wval, 4'hF);
        s_awaddr = 7'h18; s_araddr = 7'h1C; s_wdata = ~wval;
        for (int k = 0; k < 5; k++) begin
            vectors++;
            if ({s_awready, s_wready, s_arready} !== 3'b000) begin
                miscompares++;
                $display("FAIL stall_ready_%0d: got %b want 000", k,
                         {s_awready, s_wready, s_arready});
            end
            vectors++;
            if (s_bvalid !== 1'b1 || s_bresp !== 2'b00 || s_rvalid !== 1'b1 ||
                s_rresp !== 2'b00 || s_rdata !== exp_rd) begin
                miscompares++;
                $display("FAIL stall_hold_%0d: bv=%b br=%b rv=%b rr=%b rd=%h want 1/00/1/00/%h",
                         k, s_bvalid, s_bresp, s_rvalid, s_rresp, s_rdata, exp_rd);
            end
            tick();
        end
        s_awvalid = 0; s_wvalid = 0; s_arvalid = 0;
        s_bready = 1;
        s_rready = 1;
        tick();
        core_rd_addr = 5'd6;
        #1;
        vectors++;
        if (s_bvalid !== 1'b0 || s_rvalid !== 1'b0 || core_rd_data !== model[6]) begin
            miscompares++;
            $display("FAIL stall_release: bv=%b rv=%b reg6=%h want 0/0/%h",
                     s_bvalid, s_rvalid, core_rd_data, model[6]);
        end
    endtask

    task automatic test_same_edge();
        logic [1:0]  resp;
        logic [31:0] data;
        int lat;
        bit ok;
        do_write(7'h10, 32'h5, 4'hF, 0, 0, resp, lat, ok);
        model_write(7'h10, 32'h5, 4'hF);
        s_awaddr = 7'h10; s_wdata = 32'h9; s_wstrb = 4'hF; s_araddr = 7'h11;
        s_awvalid = 1; s_wvalid = 1; s_arvalid = 1;
        tick();
        s_awvalid = 0; s_wvalid = 0; s_arvalid = 0;
        vectors++;
        if (s_rvalid !== 1'b1 || s_rdata !== 32'h5 || s_bvalid !== 1'b1) begin
            miscompares++;
            $display("FAIL same_edge: rv=%b rd=%h bv=%b want 1/00000005/1",
                     s_rvalid, s_rdata, s_bvalid);
        end
        model_write(7'h10, 32'h9, 4'hF);
        tick();
        do_read(7'h13, data, resp, lat, ok);
        vectors++;
        if (!ok || data !== 32'h9) begin
            miscompares++;
            $display("FAIL same_edge_after: ok=%0b data=%h want 1/00000009", ok, data);
        end
    endtask

    task automatic test_out_of_range();
        logic [1:0]  resp;
        logic [31:0] data;
        int lat;
        bit ok;
        bit bad = 0;
        do_write(7'h40, 32'hCAFEF00D, 4'hF, 0, 0, resp, lat, ok);
        vectors++;
        if (!ok || resp !== 2'b10) begin
            miscompares++;
            $display("FAIL oor_write: ok=%0b resp=%b want 1/10", ok, resp);
        end
        for (int i = 0; i < 32; i++) begin
            core_rd_addr = 5'(i);
            #1;
            if (core_rd_data !== model[i]) bad = 1;
        end
        vectors++;
        if (bad) begin
            miscompares++;
            $display("FAIL oor_no_change: a register differs from the model");
        end
        do_read(7'h40, data, resp, lat, ok);
        vectors++;
        if (!ok || resp !== 2'b10 || data !== 32'h0) begin
            miscompares++;
            $display("FAIL oor_read: ok=%0b resp=%b data=%h want 1/10/0", ok, resp, data);
        end
    endtask

    task automatic test_random();
        logic [1:0]  resp;
        logic [31:0] data;
        logic [6:0]  addr;
        logic [31:0] wd;
        logic [3:0]  st;
        int lat;
        bit ok;
        for (int n = 0; n < 60; n++) begin
            addr = 7'($urandom_range(0, 127));
            if ($urandom_range(0, 1) == 0) begin
                wd = $urandom;
                st = 4'($urandom);
                do_write(addr, wd, st, $urandom_range(0, 3), $urandom_range(0, 3),
                         resp, lat, ok);
                model_write(addr, wd, st);
                vectors++;
                if (!ok || resp !== model_resp(addr) || lat !== 0) begin
                    miscompares++;
                    $display("FAIL rand_write_%0d: addr=%h ok=%0b resp=%b lat=%0d want 1/%b/0",
                             n, addr, ok, resp, lat, model_resp(addr));
                end
            end else begin
                do_read(addr, data, resp, lat, ok);
                vectors++;
                if (!ok || data !== model_read(addr) || resp !== model_resp(addr)) begin
                    miscompares++;
                    $display("FAIL rand_read_%0d: addr=%h data=%h resp=%b want %h/%b",
                             n, addr, data, resp, model_read(addr), model_resp(addr));
                end
            end
            core_rd_addr = 5'($urandom_range(0, 31));
            #1;
            vectors++;
            if (core_rd_data !== model[core_rd_addr]) begin
                miscompares++;
                $display("FAIL rand_core_%0d: idx=%0d got %h want %h",
                         n, core_rd_addr, core_rd_data, model[core_rd_addr]);
            end
        end
    endtask

    task automatic test_reset_mid();
        bit bad = 0;
        s_bready = 0;
        s_awaddr = 7'h04; s_wdata = 32'hA5A5A5A5; s_wstrb = 4'hF;
        s_awvalid = 1; s_wvalid = 1;
        tick();
        s_awvalid = 0; s_wvalid = 0;
        #2;
        reset_n = 0;
        #1;
        model_clear();
        vectors++;
        if (s_bvalid !== 1'b0 || s_bresp !== 2'b00) begin
            miscompares++;
            $display("FAIL reset_mid_b: bvalid=%b bresp=%b want 0/00", s_bvalid, s_bresp);
        end
        for (int i = 0; i < 32; i++) begin
            core_rd_addr = 5'(i);
            #0;
            if (core_rd_data !== 32'h0) bad = 1;
        end
        vectors++;
        if (bad) begin
            miscompares++;
            $display("FAIL reset_mid_regs: some register nonzero, want all 0");
        end
        s_bready = 1;
        tick();
        reset_n = 1;
        tick();
    endtask

    initial begin
        reset_n = 0;
        s_awaddr = '0; s_awvalid = 0; s_wdata = '0; s_wstrb = '0; s_wvalid = 0;
        s_bready = 1; s_araddr = '0; s_arvalid = 0; s_rready = 1; core_rd_addr = '0;
        model_clear();
        repeat (3) tick();
        test_reset();
        reset_n = 1;
        tick();
        test_basic();
        test_w_before_aw();
        test_strobes();
        test_backpressure();
        test_same_edge();
        test_out_of_range();
        test_random();
        test_reset_mid();
        test_reset();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
